// File: rtl/grid_memory_if.sv
// Bundle of game-logic-facing signals for the grid cell store: the
// valid/ready write port, the clear-sweep controls, the read port and the
// packed cell vector that feeds the renderer.
interface grid_memory_if #(
  parameter int SIZE_X    = 10,
  parameter int SIZE_Y    = 10,
  parameter int CELL_BITS = 1,
  parameter int XBITS     = $clog2(SIZE_X),
  parameter int YBITS     = $clog2(SIZE_Y),
  parameter int GDBITS    = CELL_BITS * SIZE_X * SIZE_Y
);
  logic                 wr_valid;
  logic                 wr_ready;
  logic [XBITS-1:0]     wr_x;
  logic [YBITS-1:0]     wr_y;
  logic [CELL_BITS-1:0] wr_data;
  logic                 wr_err;
  logic                 clr_start;
  logic [CELL_BITS-1:0] clr_value;
  logic                 busy;
  logic                 clr_done;
  logic [XBITS-1:0]     rd_x;
  logic [YBITS-1:0]     rd_y;
  logic [CELL_BITS-1:0] rd_data;
  logic [GDBITS-1:0]    data;

  // Game logic / bench side
  modport master (
    output wr_valid, wr_x, wr_y, wr_data, clr_start, clr_value, rd_x, rd_y,
    input  wr_ready, wr_err, busy, clr_done, rd_data, data
  );

  // Cell store side
  modport slave (
    input  wr_valid, wr_x, wr_y, wr_data, clr_start, clr_value, rd_x, rd_y,
    output wr_ready, wr_err, busy, clr_done, rd_data, data
  );
endinterface

// File: rtl/grid_memory.sv
// Grid cell-state store. Holds the packed cell vector that the renderer
// reads directly, and lets game logic update it with single-cell writes,
// a one-cell-per-cycle clear sweep, and a registered single-cell read.
// Cell (x,y) lives at bits [(y*SIZE_X+x)*CELL_BITS +: CELL_BITS].
module grid_memory #(
  parameter int SIZE_X    = 10,
  parameter int SIZE_Y    = 10,
  parameter int CELL_BITS = 1,
  parameter int XBITS     = $clog2(SIZE_X),
  parameter int YBITS     = $clog2(SIZE_Y),
  parameter int GDBITS    = CELL_BITS * SIZE_X * SIZE_Y
) (
  input  logic          clk,
  input  logic          reset,
  grid_memory_if.slave  bus
);

  localparam int NCELLS = SIZE_X * SIZE_Y;
  localparam int CW     = (NCELLS > 1) ? $clog2(NCELLS) : 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               state_q, state_d;
  logic [GDBITS-1:0]    cells_q, cells_d;
  logic [CW-1:0]        idx_q, idx_d;
  logic [CELL_BITS-1:0] clr_val_q, clr_val_d;
  logic [CELL_BITS-1:0] rd_data_q, rd_data_d;
  logic                 wr_err_q, wr_err_d;
  logic                 clr_done_q, clr_done_d;

  logic                 wr_fire;
  logic                 wr_ok;
  logic                 rd_ok;
  logic [31:0]          wr_lin;
  logic [31:0]          rd_lin;
  logic [31:0]          clr_lin;

  // Address decode: range checks and linear cell indices
  assign wr_fire = bus.wr_valid && (state_q == IDLE);
  assign wr_ok   = (32'(bus.wr_x) < SIZE_X) && (32'(bus.wr_y) < SIZE_Y);
  assign rd_ok   = (32'(bus.rd_x) < SIZE_X) && (32'(bus.rd_y) < SIZE_Y);
  assign wr_lin  = (32'(bus.wr_y) * SIZE_X + 32'(bus.wr_x)) * CELL_BITS;
  assign rd_lin  = (32'(bus.rd_y) * SIZE_X + 32'(bus.rd_x)) * CELL_BITS;
  assign clr_lin = 32'(idx_q) * CELL_BITS;

  // Next-state logic for the IDLE/CLEAR controller, storage and read port
  always_comb begin
    state_d    = state_q;
    cells_d    = cells_q;
    idx_d      = idx_q;
    clr_val_d  = clr_val_q;
    rd_data_d  = '0;
    wr_err_d   = 1'b0;
    clr_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        // A write and a clear request in the same cycle both take effect:
        // the write lands now, the sweep (which will overwrite it) follows.
        if (wr_fire) begin
          if (wr_ok) begin
            cells_d[wr_lin +: CELL_BITS] = bus.wr_data;
          end else begin
            wr_err_d = 1'b1;
          end
        end
        if (bus.clr_start) begin
          state_d   = CLEAR;
          clr_val_d = bus.clr_value;
          idx_d     = '0;
        end
      end
      CLEAR: begin
        cells_d[clr_lin +: CELL_BITS] = clr_val_q;
        if (idx_q == CW'(NCELLS - 1)) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Read sees storage as it stood before this edge
    if (rd_ok) begin
      rd_data_d = cells_q[rd_lin +: CELL_BITS];
    end
  end

  // State, storage and registered outputs; reset overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cells_q    <= '0;
      idx_q      <= '0;
      clr_val_q  <= '0;
      rd_data_q  <= '0;
      wr_err_q   <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cells_q    <= cells_d;
      idx_q      <= idx_d;
      clr_val_q  <= clr_val_d;
      rd_data_q  <= rd_data_d;
      wr_err_q   <= wr_err_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign bus.busy     = (state_q == CLEAR);
  assign bus.wr_ready = (state_q == IDLE);
  assign bus.wr_err   = wr_err_q;
  assign bus.clr_done = clr_done_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.data     = cells_q;

endmodule

// File: doc/grid_memory.md
# grid_memory

Cell-state store sitting directly upstream of the grid renderer/hit-tester. Holds the packed `SIZE_X*SIZE_Y*CELL_BITS` cell vector, driven continuously onto `data` for the renderer. Game logic updates it through a valid/ready single-cell write port, a multi-cycle clear sweep, and a registered single-cell read port. Cell (x,y) occupies bits `[(y*SIZE_X+x)*CELL_BITS +: CELL_BITS]`, matching the renderer's indexing.

## Interface

- `SIZE_X`, default 10: cells per row.
- `SIZE_Y`, default 10: cells per column.
- `CELL_BITS`, default 1: bits per cell.
- `XBITS`, default `$clog2(SIZE_X)`: x-coordinate width.
- `YBITS`, default `$clog2(SIZE_Y)`: y-coordinate width.
- `GDBITS`, default `CELL_BITS*SIZE_X*SIZE_Y`: packed vector width.

Ports:

- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: write port can accept.
- `wr_x` in XBITS: write cell column.
- `wr_y` in YBITS: write cell row.
- `wr_data` in CELL_BITS: value to store.
- `wr_err` out 1: one-cycle pulse, previous accepted write was out of range.
- `clr_start` in 1: start clear sweep (sampled in IDLE only).
- `clr_value` in CELL_BITS: fill value, latched with `clr_start`.
- `busy` out 1: clear sweep in progress.
- `clr_done` out 1: one-cycle pulse at sweep completion.
- `rd_x` in XBITS, `rd_y` in YBITS: read address.
- `rd_data` out CELL_BITS: registered read result.
- `data` out GDBITS: full packed cell vector, driven straight from storage registers.

## Operation

- States: IDLE, CLEAR. `busy` = (state==CLEAR). `wr_ready` = !busy.
- Write: a handshake completes when `wr_valid & wr_ready`.
  - If `wr_x<SIZE_X` and `wr_y<SIZE_Y`, the cell is updated at that edge.
  - Otherwise storage is unchanged and `wr_err` pulses the next cycle.
  - The handshake completes either way.
- Clear:
  - `clr_start` in IDLE moves the FSM to CLEAR, latches `clr_value`, and zeroes the sweep counter.
  - In CLEAR, each cycle writes the latched value to linear cell `idx`, then increments `idx`.
  - After cell `SIZE_X*SIZE_Y-1` is written, the FSM returns to IDLE and `clr_done` pulses.
  - The counter is `$clog2(SIZE_X*SIZE_Y)` bits, with no wrap past the last cell.
- `clr_start` in CLEAR is ignored. No restart and no queueing.
- Write and `clr_start` in the same IDLE cycle: the write commits at that edge and the sweep starts next cycle. The sweep overwrites the written cell.
- `wr_valid` held during CLEAR stalls, since `wr_ready`=0. The request is accepted on the first IDLE cycle after the sweep.
- Read: `rd_data` is registered from storage as it stood before the current edge (read-before-write). Out-of-range addresses return 0.
- Reset:
  - All cells become 0 and the state goes to IDLE.
  - `rd_data`, `wr_err` and `clr_done` go to 0, and `busy` goes to 0, so `wr_ready`=1.
  - Reset mid-sweep aborts the sweep with no `clr_done`.
  - Reset has priority over every other input.

## Timing

- Write accepted in cycle N: `data` and reads issued in cycle N+1 or later reflect it. A read issued in cycle N returns the old value in cycle N+1.
- `wr_err` is high for exactly cycle N+1.
- Clear with C = `SIZE_X*SIZE_Y` cells and `clr_start` sampled in cycle N:
  - `busy` is high in cycles N+1..N+C.
  - Cell k is written at the end of cycle N+1+k.
  - `busy` is low and `clr_done` is high in cycle N+C+1.
  - The next `clr_start` is accepted in cycle N+C+1.
- Read latency is 1 cycle and is unaffected by `busy`.
- `data` has no extra pipeline stage: it is the storage register outputs.

## Test plan

- Reset, then a 10x10, CELL_BITS=1 configuration → `data`=0, `busy`=0, `wr_ready`=1, `rd_data`=0, and no pulses on `wr_err`/`clr_done`.
- Write (3,7)=1 in cycle N → bit 73 of `data` is high from cycle N+1. Read of (3,7) issued in N returns 0; issued in N+1 returns 1 in N+2.
- Write (10,2) → `data` unchanged and `wr_err`=1 for exactly one cycle. Read of (12,0) returns 0.
- CELL_BITS=2 override, `clr_start` with `clr_value`=2'b10 in cycle N:
  - `busy` high for exactly 100 cycles and `clr_done` high in N+101.
  - `data` = {100{2'b10}}.
  - A `wr_valid` held during the sweep completes in N+101.
- Simultaneous write (0,0)=1 and `clr_start` with value 0 → the write is accepted in cycle N, and cell 0 reads 0 after the sweep. A second `clr_start` mid-sweep is ignored: the sweep still lasts exactly 100 cycles.
- `reset` asserted in the 40th sweep cycle → next cycle `busy`=0 and `data`=0, and `clr_done` never pulses.
